// File: rtl/fifo_buffer_ext.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads are registered (1-cycle latency).
module fifo_buffer_ext #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_BITS = 3,
    parameter int AF_THRESH  = (2 ** DEPTH_BITS) - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DEPTH_BITS:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] CNT_FULL = (DEPTH_BITS + 1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] CNT_AF   = (DEPTH_BITS + 1)'(AF_THRESH);
    localparam logic [DEPTH_BITS:0] CNT_AE   = (DEPTH_BITS + 1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_BITS-1:0] wptr;
    logic [DEPTH_BITS-1:0] rptr;
    logic [DEPTH_BITS:0]   count_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  rd_ok;
    logic                  wr_ok;

    // Status flags decode from the registered count only, so no input reaches them combinationally.
    assign count        = count_q;
    assign full         = (count_q == CNT_FULL);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
    assign rd_ok = rd_en & ~empty;
    assign wr_ok = wr_en & (~full | rd_ok);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            wptr        <= '0;
            rptr        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;

            if (wr_ok && !rd_ok) begin
                count_q <= count_q + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count_q <= count_q - 1'b1;
            end

            // Setting an error flag wins over a clear arriving in the same cycle.
            overflow_q  <= (overflow_q & ~clr_err) | (wr_en & ~wr_ok);
            underflow_q <= (underflow_q & ~clr_err) | (rd_en & empty);
        end
    end

    // NOTE: the storage array has no reset; pointers and count alone define which words are valid.
    always_ff @(posedge clk) begin
        if (wr_ok && !reset) begin
            mem[wptr] <= wr_data;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented as soon as it exists; rd_en acknowledges and pops it.
    assign rd_data = empty ? '0 : mem[rptr];
`else
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_ok) begin
            rd_data_q <= mem[rptr];
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_fifo_buffer_ext.sv
// Scoreboard bench for fifo_buffer_ext (DATA_WIDTH=4, DEPTH_BITS=3, AF_THRESH=6, AE_THRESH=1).
// Works in both the standard build and with FIFO_FWFT_EN defined.
module tb_fifo_buffer_ext;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [3:0] rd_data;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: words pushed when a write is accepted, popped when a read is accepted.
    logic [3:0] sb [$];
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;
    logic [3:0] m_rd  = '0;

    fifo_buffer_ext #(
        .DATA_WIDTH(4),
        .DEPTH_BITS(3),
        .AF_THRESH (6),
        .AE_THRESH (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .clr_err     (clr_err),
        .rd_data     (rd_data),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {count, full, empty, almost_full, almost_empty, overflow, underflow, rd_data}
    function automatic logic [13:0] expected_vec();
        int n = sb.size();
        logic [3:0] rd_exp;
`ifdef FIFO_FWFT_EN
        rd_exp = (n != 0) ? sb[0] : 4'h0;
`else
        rd_exp = m_rd;
`endif
        return {4'(n), n == DEPTH, n == 0, n >= 6, n <= 1, m_ovf, m_unf, rd_exp};
    endfunction

    function automatic logic [13:0] observed_vec();
        return {count, full, empty, almost_full, almost_empty, overflow, underflow, rd_data};
    endfunction

    // Drive one cycle of requests, then advance the scoreboard model by the same edge.
    task automatic step(input bit wr, input logic [3:0] d, input bit rd, input bit clr);
        int n      = sb.size();
        bit rd_acc = rd && (n > 0);
        bit wr_acc = wr && ((n < DEPTH) || rd_acc);
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        clr_err = clr;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        if (rd_acc) m_rd = sb.pop_front();
        if (wr_acc) sb.push_back(d);
        m_ovf = (m_ovf && !clr) || (wr && !wr_acc);
        m_unf = (m_unf && !clr) || (rd && (n == 0));
    endtask

    task automatic apply_reset(input int cycles);
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 4'h5;
        rd_en   = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        sb.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_rd  = '0;
    endtask

    task automatic test_reset();
        apply_reset(2);
        n_checks++;
        if (observed_vec() !== 14'b0000_0101_00_0000) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b", observed_vec(), 14'b0000_0101_00_0000);
        end
    endtask

    task automatic test_basic();
        logic [3:0] words [2] = '{4'hF, 4'h4};
        for (int i = 0; i < 2; i++) begin
            step(1'b1, words[i], 1'b0, 1'b0);
            n_checks++;
            if (observed_vec() !== expected_vec()) begin
                n_fail++;
                $display("FAIL basic_write%0d: got %h want %h", i, observed_vec(), expected_vec());
            end
        end
        for (int i = 0; i < 2; i++) begin
`ifdef FIFO_FWFT_EN
            n_checks++;
            if (rd_data !== words[i]) begin
                n_fail++;
                $display("FAIL basic_head%0d: got %h want %h", i, rd_data, words[i]);
            end
`endif
            step(1'b0, 4'h0, 1'b1, 1'b0);
`ifndef FIFO_FWFT_EN
            n_checks++;
            if (rd_data !== words[i]) begin
                n_fail++;
                $display("FAIL basic_read%0d: got %h want %h", i, rd_data, words[i]);
            end
`endif
            n_checks++;
            if (observed_vec() !== expected_vec()) begin
                n_fail++;
                $display("FAIL basic_state%0d: got %h want %h", i, observed_vec(), expected_vec());
            end
        end
        n_checks++;
        if (empty !== 1'b1 || count !== 4'd0) begin
            n_fail++;
            $display("FAIL basic_end: got empty=%b count=%0d want empty=1 count=0", empty, count);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 4'(i), 1'b0, 1'b0);
            n_checks++;
            if (observed_vec() !== expected_vec()) begin
                n_fail++;
                $display("FAIL fill%0d: got %h want %h", i, observed_vec(), expected_vec());
            end
        end
        step(1'b1, 4'hA, 1'b0, 1'b0);
        n_checks++;
        if (overflow !== 1'b1 || count !== 4'd8 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set: got ovf=%b count=%0d full=%b want 1 8 1", overflow, count, full);
        end
        step(1'b0, 4'h0, 1'b0, 1'b1);
        n_checks++;
        if (observed_vec() !== expected_vec() || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clr: got %h want %h", observed_vec(), expected_vec());
        end
    endtask

    task automatic test_full_rw();
        logic [3:0] exp_seq [8] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h6};
        step(1'b1, 4'h6, 1'b1, 1'b0);
        n_checks++;
        if (count !== 4'd8 || overflow !== 1'b0 || observed_vec() !== expected_vec()) begin
            n_fail++;
            $display("FAIL full_rw: got %h want %h", observed_vec(), expected_vec());
        end
        for (int i = 0; i < 8; i++) begin
`ifdef FIFO_FWFT_EN
            n_checks++;
            if (rd_data !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL wrap_head%0d: got %h want %h", i, rd_data, exp_seq[i]);
            end
`endif
            step(1'b0, 4'h0, 1'b1, 1'b0);
`ifndef FIFO_FWFT_EN
            n_checks++;
            if (rd_data !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL wrap_read%0d: got %h want %h", i, rd_data, exp_seq[i]);
            end
`endif
            n_checks++;
            if (observed_vec() !== expected_vec()) begin
                n_fail++;
                $display("FAIL wrap_state%0d: got %h want %h", i, observed_vec(), expected_vec());
            end
        end
    endtask

    task automatic test_underflow();
        step(1'b0, 4'h0, 1'b1, 1'b0);
        n_checks++;
        if (underflow !== 1'b1 || count !== 4'd0 || observed_vec() !== expected_vec()) begin
            n_fail++;
            $display("FAIL underflow_set: got %h want %h", observed_vec(), expected_vec());
        end
        step(1'b1, 4'hA, 1'b1, 1'b0);
        n_checks++;
        if (count !== 4'd1 || underflow !== 1'b1 || observed_vec() !== expected_vec()) begin
            n_fail++;
            $display("FAIL empty_rw: got %h want %h", observed_vec(), expected_vec());
        end
        step(1'b0, 4'h0, 1'b1, 1'b0);
        // Underflow raised while clr_err is asserted must remain set.
        step(1'b0, 4'h0, 1'b1, 1'b1);
        n_checks++;
        if (underflow !== 1'b1 || observed_vec() !== expected_vec()) begin
            n_fail++;
            $display("FAIL set_beats_clr: got %h want %h", observed_vec(), expected_vec());
        end
        step(1'b0, 4'h0, 1'b0, 1'b1);
        n_checks++;
        if (underflow !== 1'b0 || observed_vec() !== expected_vec()) begin
            n_fail++;
            $display("FAIL underflow_clr: got %h want %h", observed_vec(), expected_vec());
        end
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 9), 1'b0, 1'b0);
        apply_reset(1);
        n_checks++;
        if (observed_vec() !== 14'b0000_0101_00_0000) begin
            n_fail++;
            $display("FAIL midop_reset: got %b want %b", observed_vec(), 14'b0000_0101_00_0000);
        end
        step(1'b1, 4'h7, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        n_checks++;
        if (observed_vec() !== expected_vec()) begin
            n_fail++;
            $display("FAIL midop_after: got %h want %h", observed_vec(), expected_vec());
        end
    endtask

`ifdef FIFO_FWFT_EN
    task automatic test_fwft();
        step(1'b1, 4'h3, 1'b0, 1'b0);
        n_checks++;
        if (rd_data !== 4'h3 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL fwft_show: got rd_data=%h empty=%b want 3 0", rd_data, empty);
        end
        step(1'b0, 4'h0, 1'b1, 1'b0);
        n_checks++;
        if (rd_data !== 4'h0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL fwft_pop: got rd_data=%h empty=%b want 0 1", rd_data, empty);
        end
    endtask
`endif

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
            n_checks++;
            if (observed_vec() !== expected_vec()) begin
                n_fail++;
                $display("FAIL random%0d: got %h want %h", i, observed_vec(), expected_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_overflow();
        test_full_rw();
        test_underflow();
        test_reset_midop();
`ifdef FIFO_FWFT_EN
        test_fwft();
`endif
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_buffer_ext.md
# fifo_buffer_ext

Parametrised synchronous FIFO: the next generation of the team's basic single-clock FIFO buffer. Adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags with clear, defined simultaneous read/write at the full boundary, and an optional first-word-fall-through (FWFT) read mode. Sits between a producer and a consumer in the same clock domain as a drop-in replacement for the basic FIFO, with extra outputs.

## Interface
- DATA_WIDTH, 8, word width in bits (>=1)
- DEPTH_BITS, 3, log2 of depth; DEPTH = 2**DEPTH_BITS entries
- AF_THRESH, DEPTH-1, almost_full asserted when count >= AF_THRESH (1..DEPTH)
- AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- rd_en  in  1  read request (pop acknowledge in FWFT mode)
- clr_err  in  1  clears overflow/underflow (synchronous)
- rd_data  out  DATA_WIDTH  read word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- count  out  DEPTH_BITS+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write rejected
- underflow  out  1  sticky: read on empty

## Operation
- Storage: DEPTH x DATA_WIDTH array; write pointer wptr and read pointer rptr, DEPTH_BITS wide, wrap naturally modulo DEPTH. Registered count, DEPTH_BITS+1 wide.
- rd_ok = rd_en & ~empty; wr_ok = wr_en & (~full | rd_ok).
- wr_ok: mem[wptr] <= wr_data, wptr <= wptr+1. rd_ok: rptr <= rptr+1.
- count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither. Never exceeds DEPTH, never below 0.
- Full + wr_en + rd_en: both accepted, count stays DEPTH, no overflow.
- Empty + wr_en + rd_en: write accepted, read rejected, underflow set, count -> 1.
- overflow set when wr_en & ~wr_ok; underflow set when rd_en & empty. Both hold until clr_err or reset. Set wins over clr_err in the same cycle.
- Rejected operations leave pointers, memory and count unchanged.
- full, empty, almost_full, almost_empty decode combinationally from registered count only (no input paths).
- Reset: wptr=rptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=underflow=0, rd_data=0. Memory contents not reset. Reset mid-operation discards all stored words; requests in the reset cycle are ignored.

## Timing
- Standard mode: rd_data <= mem[rptr] on the rd_ok edge; valid from the following cycle; holds last value when no read. Read latency 1 cycle.
- Write-to-read: word written at edge N is readable (rd_ok possible) from edge N+1; earliest rd_data at N+2 (standard).
- Flags and count reflect operations one cycle after the accepting edge.
- No combinational path from wr_en/rd_en to any output (standard mode).

## Configuration
- FIFO_FWFT_EN defined: rd_data = mem[rptr] combinationally whenever empty=0, DATA_WIDTH'b0 when empty=1; head word visible the cycle after its write edge with no rd_en; rd_en pops the visible word (rd_ok advances rptr). All other behaviour identical.
- FIFO_FWFT_EN undefined: standard registered read, 1-cycle latency as above.

## Test plan
(DATA_WIDTH=4, DEPTH_BITS=3, AF_THRESH=6, AE_THRESH=1 unless noted)
- Reset held 2 cycles, then released -> empty=1, almost_empty=1, full=0, count=0, rd_data=0, overflow=underflow=0.
- Write 4'hF, 4'h4, then two reads (standard) -> rd_data 4'hF then 4'h4 one cycle after each rd_en; count 0,1,2,1,0; empty=1 at end.
- Write 8 words 1..8 -> almost_full=1 at count 6, full=1 at count 8; 9th write 4'hA -> overflow=1, count stays 8; clr_err -> overflow=0.
- Full, wr_en+rd_en with 4'h6 -> count stays 8, next 8 reads return 2..8,6 (wrap-around verified), no overflow.
- Empty, rd_en alone -> underflow=1, count 0; then wr_en+rd_en with 4'hA -> count 1, underflow remains 1.
- FIFO_FWFT_EN defined: write 4'h3 at edge N -> rd_data=4'h3 from cycle N+1 without rd_en; rd_en pops, rd_data=0, empty=1.
